clk_divider_prog: RTL

//  Programmable, parametrised successor to the fixed 1 Hz clk_divider.

---
 rtl/clk_divider_prog_if.sv | 21 ++
 rtl/clk_divider_prog.sv | 78 +++++++
 2 files changed

// File: rtl/clk_divider_prog_if.sv
// Control and status signals of the programmable clock divider.
interface clk_divider_prog_if #(
    parameter int unsigned CNT_W = 27
);
    logic             en;
    logic             div_load;
    logic [CNT_W-1:0] div_val;
    logic             clk_out;
    logic             tick;
    logic             pend;

    modport master (
        output en, div_load, div_val,
        input  clk_out, tick, pend
    );

    modport slave (
        input  en, div_load, div_val,
        output clk_out, tick, pend
    );
endinterface

// File: rtl/clk_divider_prog.sv
// Programmable clock divider: 50%-duty clk_out at f/(2D) and a one-cycle tick at f/D,
// with divisor changes deferred to the next period boundary.
module clk_divider_prog #(
    parameter int unsigned CNT_W       = 27,
    parameter int unsigned DEFAULT_DIV = 50_000_000
) (
    input  logic               clk,
    input  logic               rst,
    clk_divider_prog_if.slave  bus
);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] div_q, div_d;
    logic [CNT_W-1:0] pend_val_q, pend_val_d;
    logic             pend_q, pend_d;
    logic             clk_out_q, clk_out_d;
    logic             tick_q, tick_d;
    logic             term_c;
    logic [CNT_W-1:0] load_val_c;

    // A requested divisor of zero is treated as one.
    assign load_val_c = (bus.div_val == '0) ? CNT_W'(1) : bus.div_val;
    assign term_c     = bus.en && (cnt_q == (div_q - CNT_W'(1)));

    always_comb begin
        cnt_d      = cnt_q;
        div_d      = div_q;
        pend_val_d = pend_val_q;
        pend_d     = pend_q;
        clk_out_d  = clk_out_q;
        tick_d     = 1'b0;

        if (bus.en) begin
            if (term_c) begin
                cnt_d     = '0;
                tick_d    = 1'b1;
                clk_out_d = ~clk_out_q;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end

        // On a boundary a same-edge load wins over an older pending value.
        if (term_c && bus.div_load) begin
            div_d  = load_val_c;
            pend_d = 1'b0;
        end else if (term_c && pend_q) begin
            div_d  = pend_val_q;
            pend_d = 1'b0;
        end else if (bus.div_load) begin
            pend_val_d = load_val_c;
            pend_d     = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q      <= '0;
            div_q      <= CNT_W'(DEFAULT_DIV);
            pend_val_q <= '0;
            pend_q     <= 1'b0;
            clk_out_q  <= 1'b0;
            tick_q     <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            div_q      <= div_d;
            pend_val_q <= pend_val_d;
            pend_q     <= pend_d;
            clk_out_q  <= clk_out_d;
            tick_q     <= tick_d;
        end
    end

    assign bus.clk_out = clk_out_q;
    assign bus.tick    = tick_q;
    assign bus.pend    = pend_q;

endmodule
